core_test_sequencer: RTL

- Synthesizable, parametrised self-checking harness for the single-cycle RV32I core; replaces the hand-written per-instruction benches.
- Holds a loadable program buffer and a table of expected register values.
- On start it loads the program into the core's instruction memory, pulses the core reset and runs the core for a fixed cycle budget.
- It then reads back the selected registers through the debug port and reports pass/fail with first-failure detail.

---
 rtl/core_test_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_test_sequencer.sv
// ============================================================================
// Module   : core_test_sequencer
// Purpose  : Loads a program into the RV32I core, runs it for a fixed budget
//            and checks selected registers through the debug read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_test_sequencer #(
  parameter int XLEN        = 32,
  parameter int PROG_DEPTH  = 16,
  parameter int CHECK_COUNT = 4,
  parameter int RUN_CYCLES  = 10,
  parameter int IMEM_AW     = 10,
  parameter int RF_AW       = 5,
  localparam int PIW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
  localparam int CIW = (CHECK_COUNT > 1) ? $clog2(CHECK_COUNT) : 1,
  localparam int AW  = (PIW > CIW) ? PIW : CIW
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cfg_we_i,
  input  logic               cfg_sel_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [XLEN-1:0]    cfg_wdata_i,
  input  logic [RF_AW-1:0]   cfg_reg_i,
  input  logic [PIW:0]       prog_len_i,
  input  logic [CIW:0]       check_len_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CIW:0]       fail_count_o,
  output logic [CIW-1:0]     fail_index_o,
  output logic [XLEN-1:0]    fail_actual_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [XLEN-1:0]    imem_wdata_o,
  output logic               core_reset_n_o,
  output logic               core_en_o,
  output logic [RF_AW-1:0]   rf_dbg_addr_o,
  input  logic [XLEN-1:0]    rf_dbg_data_i
);

  localparam int CNT_MAX = (PROG_DEPTH > RUN_CYCLES) ? PROG_DEPTH : RUN_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CRST  = 3'd2,
    S_RUN   = 3'd3,
    S_CHK_A = 3'd4,
    S_CHK_B = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CIW:0]      chk_idx_q, chk_idx_d;
  logic [PIW:0]      prog_len_q, prog_len_d;
  logic [CIW:0]      check_len_q, check_len_d;
  logic [CIW:0]      fail_count_q, fail_count_d;
  logic [CIW-1:0]    fail_index_q, fail_index_d;
  logic [XLEN-1:0]   fail_actual_q, fail_actual_d;

  logic [XLEN-1:0]   prog_mem_q [PROG_DEPTH];
  logic [XLEN-1:0]   chk_val_q  [CHECK_COUNT];
  logic [RF_AW-1:0]  chk_reg_q  [CHECK_COUNT];

  logic              cfg_prog_we;
  logic              cfg_chk_we;
  logic [CIW-1:0]    chk_sel;
  logic              chk_mismatch;

  // Out-of-range writes are dropped rather than aliased onto a valid entry.
  assign cfg_prog_we = cfg_we_i && !busy_o && !cfg_sel_i &&
                       (32'(cfg_addr_i) < PROG_DEPTH);
  assign cfg_chk_we  = cfg_we_i && !busy_o &&  cfg_sel_i &&
                       (32'(cfg_addr_i) < CHECK_COUNT);

  assign chk_sel      = chk_idx_q[CIW-1:0];
  assign chk_mismatch = (rf_dbg_data_i != chk_val_q[chk_sel]);

  assign fail_count_o  = fail_count_q;
  assign fail_index_o  = fail_index_q;
  assign fail_actual_o = fail_actual_q;

  always_ff @(posedge clk_i) begin
    if (cfg_prog_we) begin
      prog_mem_q[cfg_addr_i[PIW-1:0]] <= cfg_wdata_i;
    end
    if (cfg_chk_we) begin
      chk_val_q[cfg_addr_i[CIW-1:0]] <= cfg_wdata_i;
      chk_reg_q[cfg_addr_i[CIW-1:0]] <= cfg_reg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      chk_idx_q     <= '0;
      prog_len_q    <= '0;
      check_len_q   <= '0;
      fail_count_q  <= '0;
      fail_index_q  <= '0;
      fail_actual_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chk_idx_q     <= chk_idx_d;
      prog_len_q    <= prog_len_d;
      check_len_q   <= check_len_d;
      fail_count_q  <= fail_count_d;
      fail_index_q  <= fail_index_d;
      fail_actual_q <= fail_actual_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    chk_idx_d      = chk_idx_q;
    prog_len_d     = prog_len_q;
    check_len_d    = check_len_q;
    fail_count_d   = fail_count_q;
    fail_index_d   = fail_index_q;
    fail_actual_d  = fail_actual_q;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    pass_o         = 1'b0;
    imem_we_o      = 1'b0;
    imem_addr_o    = '0;
    imem_wdata_o   = '0;
    core_reset_n_o = 1'b0;
    core_en_o      = 1'b0;
    rf_dbg_addr_o  = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          done_o         = 1'b1;
          pass_o         = (fail_count_q == '0);
          core_reset_n_o = 1'b1;
        end
        if (start_i) begin
          state_d       = S_LOAD;
          cnt_d         = '0;
          chk_idx_d     = '0;
          fail_count_d  = '0;
          fail_index_d  = '0;
          fail_actual_d = '0;
          prog_len_d    = (32'(prog_len_i) > PROG_DEPTH) ?
                          (PIW+1)'(PROG_DEPTH) : prog_len_i;
          check_len_d   = (32'(check_len_i) > CHECK_COUNT) ?
                          (CIW+1)'(CHECK_COUNT) : check_len_i;
        end
      end

      S_LOAD: begin
        busy_o      = 1'b1;
        imem_we_o   = 1'b1;
        imem_addr_o = IMEM_AW'(cnt_q);
        // Words past the program are zeroed so stale code cannot run.
        if (32'(cnt_q) < 32'(prog_len_q)) begin
          imem_wdata_o = prog_mem_q[cnt_q[PIW-1:0]];
        end
        if (cnt_q == CNTW'(PROG_DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = S_CRST;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_CRST: begin
        busy_o = 1'b1;
        if (cnt_q == CNTW'(1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_RUN: begin
        busy_o         = 1'b1;
        core_reset_n_o = 1'b1;
        core_en_o      = 1'b1;
        if (cnt_q == CNTW'(RUN_CYCLES - 1)) begin
          cnt_d     = '0;
          chk_idx_d = '0;
          state_d   = (check_len_q == '0) ? S_DONE : S_CHK_A;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_CHK_A: begin
        busy_o         = 1'b1;
        core_reset_n_o = 1'b1;
        rf_dbg_addr_o  = chk_reg_q[chk_sel];
        state_d        = S_CHK_B;
      end

      S_CHK_B: begin
        busy_o         = 1'b1;
        core_reset_n_o = 1'b1;
        rf_dbg_addr_o  = chk_reg_q[chk_sel];
        if (chk_mismatch) begin
          fail_count_d = fail_count_q + (CIW+1)'(1);
          if (fail_count_q == '0) begin
            fail_index_d  = chk_sel;
            fail_actual_d = rf_dbg_data_i;
          end
        end
        chk_idx_d = chk_idx_q + (CIW+1)'(1);
        state_d   = (chk_idx_q + (CIW+1)'(1) == check_len_q) ? S_DONE : S_CHK_A;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
